// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller sitting between the ID/EX hazard and branch
// logic and the program-counter register.
//
// Parameters:
//   RESET_PC   value presented on pc_next while reset is high
//   IRQ_VEC    interrupt vector
//   ILLOP_VEC  illegal-op / exception vector
//
// Ports:
//   sysclk         system clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   pc_cur         current PC register output
//   stall_req      load-use hazard, hold the PC
//   branch_taken   EX-stage branch resolved taken, with branch_target
//   jump_en        ID-stage j/jal, with jump_target
//   jr_en          ID-stage jr/jalr, with jr_target
//   eret_en        ID-stage exception return
//   illop          ID-stage undefined/illegal instruction
//   irq            external interrupt request (level, already synchronised)
//   pc_write       PC register write enable
//   pc_next        PC register input
//   flush_if       squash IF/ID
//   flush_id       squash ID/EX
//   epc            saved return address
//   kernel         kernel mode flag, equal to pc_cur[31]
//
// pc_write, pc_next and the flushes are combinational; a redirect lands in the
// PC register at the next sysclk edge.

module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0008
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        stall_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic        eret_en,
  input  logic        illop,
  input  logic        irq,
  output logic        pc_write,
  output logic [31:0] pc_next,
  output logic        flush_if,
  output logic        flush_id,
  output logic [31:0] epc,
  output logic        kernel
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] TRAP = 1'b1;

  logic [0:0]  fsm_r;
  logic [0:0]  fsm_nxt_s;
  logic        irq_pending_r;
  logic        irq_nxt_s;
  logic [31:0] epc_r;
  logic [31:0] epc_nxt_s;
  logic [31:0] pc_plus4_s;

  // Sequential address; wraps naturally modulo 2^32.
  assign pc_plus4_s = pc_cur + 32'd4;
  // Kernel mode is the top PC bit, no latency.
  assign kernel     = pc_cur[31];
  assign epc        = epc_r;

  // Next-PC selection, flush generation and next-state computation.
  always_comb begin
    pc_next   = pc_plus4_s;
    pc_write  = 1'b1;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    fsm_nxt_s = RUN;
    epc_nxt_s = epc_r;

    // Interrupts are masked (and not queued) while in kernel mode.
    if (pc_cur[31]) begin
      irq_nxt_s = 1'b0;
    end else if (irq) begin
      irq_nxt_s = 1'b1;
    end else begin
      irq_nxt_s = irq_pending_r;
    end

    if (reset) begin
      pc_next  = RESET_PC;
      pc_write = 1'b0;
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else begin
      case (fsm_r)
        TRAP: begin
          // One-cycle cleanup: squash the instruction fetched before the
          // redirect; all redirect sources and illop are ignored here.
          flush_id = 1'b1;
          if (stall_req) begin
            pc_write = 1'b0;
            pc_next  = pc_cur;
          end else begin
            pc_write = 1'b1;
            pc_next  = pc_plus4_s;
          end
        end
        RUN: begin
          if (illop) begin
            // Trapping instruction is re-executed after eret.
            pc_next   = ILLOP_VEC;
            flush_if  = 1'b1;
            flush_id  = 1'b1;
            epc_nxt_s = pc_cur;
            fsm_nxt_s = TRAP;
          end else if (irq_pending_r && !pc_cur[31]) begin
            // A taken EX branch is the older instruction's real successor.
            pc_next   = IRQ_VEC;
            flush_if  = 1'b1;
            flush_id  = 1'b1;
            epc_nxt_s = branch_taken ? branch_target : pc_cur;
            fsm_nxt_s = TRAP;
            irq_nxt_s = 1'b0;
          end else if (branch_taken) begin
            // EX is older than ID, so it beats stalls and ID jumps.
            pc_next  = branch_target;
            flush_if = 1'b1;
            flush_id = 1'b1;
          end else if (stall_req) begin
            pc_write = 1'b0;
            pc_next  = pc_cur;
          end else if (jr_en) begin
            // jr_en with jump_en is an illegal decode; jr wins silently.
            pc_next  = jr_target;
            flush_if = 1'b1;
          end else if (jump_en) begin
            pc_next  = jump_target;
            flush_if = 1'b1;
          end else if (eret_en) begin
            if (pc_cur[31]) begin
              pc_next  = epc_r;
              flush_if = 1'b1;
            end else begin
              // eret from user mode is a privilege violation.
              pc_next   = ILLOP_VEC;
              flush_if  = 1'b1;
              flush_id  = 1'b1;
              epc_nxt_s = pc_cur;
              fsm_nxt_s = TRAP;
            end
          end else begin
            pc_next  = pc_plus4_s;
            pc_write = 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: hold the PC and recover to RUN.
          pc_write  = 1'b0;
          pc_next   = pc_cur;
          flush_if  = 1'b1;
          flush_id  = 1'b1;
          fsm_nxt_s = RUN;
        end
      endcase
    end
  end

  // State registers; reset also aborts an in-flight trap.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      fsm_r         <= RUN;
      irq_pending_r <= 1'b0;
      epc_r         <= 32'h0000_0000;
    end else begin
      fsm_r         <= fsm_nxt_s;
      irq_pending_r <= irq_nxt_s;
      epc_r         <= epc_nxt_s;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer. pc_cur is driven directly as
// a stimulus vector; combinational outputs are sampled on the falling edge,
// epc is sampled after the rising edge that updates it.

module tb_pc_sequencer;

  logic        sysclk;
  logic        reset;
  logic [31:0] pc_cur;
  logic        stall_req;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        jr_en;
  logic [31:0] jr_target;
  logic        eret_en;
  logic        illop;
  logic        irq;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        flush_if;
  logic        flush_id;
  logic [31:0] epc;
  logic        kernel;

  int checks;
  int errors;

  pc_sequencer dut (
    .sysclk        (sysclk),
    .reset         (reset),
    .pc_cur        (pc_cur),
    .stall_req     (stall_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .jr_en         (jr_en),
    .jr_target     (jr_target),
    .eret_en       (eret_en),
    .illop         (illop),
    .irq           (irq),
    .pc_write      (pc_write),
    .pc_next       (pc_next),
    .flush_if      (flush_if),
    .flush_id      (flush_id),
    .epc           (epc),
    .kernel        (kernel)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the four combinational outputs together.
  task automatic chk_out(input string tag, input logic [31:0] exp_next, input logic exp_wr,
                         input logic exp_fif, input logic exp_fid);
    chk({tag, ".pc_next"}, pc_next, exp_next);
    chk({tag, ".pc_write"}, {31'd0, pc_write}, {31'd0, exp_wr});
    chk({tag, ".flush_if"}, {31'd0, flush_if}, {31'd0, exp_fif});
    chk({tag, ".flush_id"}, {31'd0, flush_id}, {31'd0, exp_fid});
  endtask

  task automatic idle();
    stall_req     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump_en       = 1'b0;
    jump_target   = 32'h0;
    jr_en         = 1'b0;
    jr_target     = 32'h0;
    eret_en       = 1'b0;
    illop         = 1'b0;
    irq           = 1'b0;
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    reset  = 1'b1;
    pc_cur = 32'h0040_0000;

    // 1. Reset for two cycles
    @(negedge sysclk);
    chk_out("rst1", 32'h0040_0000, 1'b0, 1'b1, 1'b1);
    tick();
    @(negedge sysclk);
    chk_out("rst2", 32'h0040_0000, 1'b0, 1'b1, 1'b1);
    tick();
    chk("rst_epc", epc, 32'h0);
    reset = 1'b0;
    @(negedge sysclk);
    chk_out("run0", 32'h0040_0004, 1'b1, 1'b0, 1'b0);
    chk("run0.kernel", {31'd0, kernel}, 32'd0);
    tick();

    // 2. Stall defers jump; branch overrides stall
    pc_cur = 32'h0040_0010; stall_req = 1'b1; jump_en = 1'b1; jump_target = 32'h0040_1000;
    @(negedge sysclk);
    chk_out("stall_jmp", 32'h0040_0010, 1'b0, 1'b0, 1'b0);
    tick();
    stall_req = 1'b1; branch_taken = 1'b1; branch_target = 32'h0040_0100;
    @(negedge sysclk);
    chk_out("br_stall", 32'h0040_0100, 1'b1, 1'b1, 1'b1);
    tick();

    // jr beats jump; plain jump
    pc_cur = 32'h0040_0100; jr_en = 1'b1; jr_target = 32'h0040_2000;
    jump_en = 1'b1; jump_target = 32'h0040_3000;
    @(negedge sysclk);
    chk_out("jr_jmp", 32'h0040_2000, 1'b1, 1'b1, 1'b0);
    tick();
    pc_cur = 32'h0040_2000; jump_en = 1'b1; jump_target = 32'h0040_3000;
    @(negedge sysclk);
    chk_out("jmp", 32'h0040_3000, 1'b1, 1'b1, 1'b0);
    tick();

    // 3. Interrupt: latched, then taken ignoring stall
    pc_cur = 32'h0040_0020; irq = 1'b1;
    @(negedge sysclk);
    chk_out("irq_latch", 32'h0040_0024, 1'b1, 1'b0, 1'b0);
    tick();
    pc_cur = 32'h0040_0020; stall_req = 1'b1;
    @(negedge sysclk);
    chk_out("irq_take", 32'h8000_0004, 1'b1, 1'b1, 1'b1);
    tick();
    chk("irq_epc", epc, 32'h0040_0020);
    pc_cur = 32'h8000_0004; irq = 1'b1;
    @(negedge sysclk);
    chk_out("irq_trap", 32'h8000_0008, 1'b1, 1'b0, 1'b1);
    chk("irq_trap.kernel", {31'd0, kernel}, 32'd1);
    tick();
    pc_cur = 32'h8000_0010; irq = 1'b1;
    @(negedge sysclk);
    chk_out("irq_masked", 32'h8000_0014, 1'b1, 1'b0, 1'b0);
    tick();
    // Masked irq was not queued; this cycle latches a fresh one
    pc_cur = 32'h0040_0030; irq = 1'b1;
    @(negedge sysclk);
    chk_out("irq_noqueue", 32'h0040_0034, 1'b1, 1'b0, 1'b0);
    tick();
    // Interrupt with a taken branch saves the branch target
    pc_cur = 32'h0040_0034; branch_taken = 1'b1; branch_target = 32'h0040_0300;
    @(negedge sysclk);
    chk_out("irq_br", 32'h8000_0004, 1'b1, 1'b1, 1'b1);
    tick();
    chk("irq_br_epc", epc, 32'h0040_0300);
    pc_cur = 32'h8000_0004; stall_req = 1'b1;
    @(negedge sysclk);
    chk_out("trap_stall", 32'h8000_0004, 1'b0, 1'b0, 1'b1);
    tick();

    // 4. Illop during stall; TRAP ignores branch and illop
    pc_cur = 32'h0040_0040; stall_req = 1'b1; illop = 1'b1;
    @(negedge sysclk);
    chk_out("illop_stall", 32'h8000_0008, 1'b1, 1'b1, 1'b1);
    tick();
    chk("illop_epc", epc, 32'h0040_0040);
    pc_cur = 32'h8000_0008; branch_taken = 1'b1; branch_target = 32'h0040_0500; illop = 1'b1;
    @(negedge sysclk);
    chk_out("trap_ign", 32'h8000_000C, 1'b1, 1'b0, 1'b1);
    tick();
    chk("trap_keep_epc", epc, 32'h0040_0040);

    // 5. Eret in kernel mode, then from user mode
    pc_cur = 32'h8000_0030; eret_en = 1'b1;
    @(negedge sysclk);
    chk_out("eret", 32'h0040_0040, 1'b1, 1'b1, 1'b0);
    tick();
    pc_cur = 32'h0040_0050; eret_en = 1'b1;
    @(negedge sysclk);
    chk_out("eret_user", 32'h8000_0008, 1'b1, 1'b1, 1'b1);
    tick();
    chk("eret_user_epc", epc, 32'h0040_0050);
    pc_cur = 32'h8000_0008;
    @(negedge sysclk);
    chk_out("eret_trap", 32'h8000_000C, 1'b1, 1'b0, 1'b1);
    tick();

    // 6. Wrap, then reset in the TRAP cycle
    pc_cur = 32'hFFFF_FFFC;
    @(negedge sysclk);
    chk_out("wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    tick();
    pc_cur = 32'h0040_0060; illop = 1'b1;
    @(negedge sysclk);
    chk_out("illop2", 32'h8000_0008, 1'b1, 1'b1, 1'b1);
    tick();
    chk("illop2_epc", epc, 32'h0040_0060);
    pc_cur = 32'h8000_0008; reset = 1'b1;
    @(negedge sysclk);
    chk_out("rst_trap", 32'h0040_0000, 1'b0, 1'b1, 1'b1);
    tick();
    chk("rst_trap_epc", epc, 32'h0);
    reset = 1'b0; pc_cur = 32'h0040_0000;
    @(negedge sysclk);
    chk_out("post_rst", 32'h0040_0004, 1'b1, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
